instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word-aligned fetch requests, keeps an
// in-order tag FIFO of request addresses, and buffers returned words as
// instruction/pc pairs. Redirects and reset flush the buffer and mark any
// still-in-flight responses for discard.
module instruction_fetch #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_four,
   output logic            misaligned_fault
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   // Counters hold values up to 2*QUEUE_DEPTH in intermediate sums.
   localparam int CW = AW + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [XLEN-1:0] fetch_pc_reg;
   logic            run_reg;
   logic            fault_reg;
   // live_reg counts in-flight requests whose responses will be kept;
   // discard_reg counts in-flight requests whose responses will be dropped.
   logic [CW-1:0]   live_reg;
   logic [CW-1:0]   discard_reg;
   logic [CW-1:0]   occ_reg;
   logic [AW-1:0]   tag_wr_reg;
   logic [AW-1:0]   tag_rd_reg;
   logic [AW-1:0]   buf_wr_reg;
   logic [AW-1:0]   buf_rd_reg;

   logic [XLEN-1:0] tag_mem      [QUEUE_DEPTH];
   logic [31:0]     buf_data_mem [QUEUE_DEPTH];
   logic [XLEN-1:0] buf_pc_mem   [QUEUE_DEPTH];

   logic            head_valid;
   logic            pop;
   logic            push;
   logic            fire;
   logic            resp_live;
   logic            resp_stale;
   logic            redirect_bad;
   logic [CW-1:0]   in_flight;
   logic [CW-1:0]   credit_used;
   logic [CW-1:0]   in_flight_left;

   // Handshake decode and credit accounting for the in-flight + buffered bound.
   always_comb begin
      head_valid     = !reset && (occ_reg != '0);
      pop            = head_valid && inst_ready && !redirect_valid;
      in_flight      = live_reg + discard_reg;
      // A slot freed by this cycle's pop can be reused by this cycle's request,
      // which is what sustains one instruction per cycle with a two-entry buffer.
      credit_used    = in_flight + occ_reg - CW'(pop);
      in_flight_left = in_flight - CW'(imem_resp_valid && (in_flight != '0));
      resp_stale     = imem_resp_valid && (discard_reg != '0);
      resp_live      = imem_resp_valid && (discard_reg == '0) && (live_reg != '0);
      push           = resp_live && !redirect_valid && !reset;
      redirect_bad   = (redirect_pc[1:0] != 2'b00);
   end

   assign imem_req_valid   = run_reg && !reset && !fault_reg && !redirect_valid &&
                             (credit_used < DEPTH_C);
   assign imem_req_addr    = fetch_pc_reg;
   assign fire             = imem_req_valid && imem_req_ready;
   assign misaligned_fault = fault_reg;

   assign inst_valid   = head_valid;
   assign instruction  = head_valid ? buf_data_mem[buf_rd_reg] : 32'h0;
   assign pc           = head_valid ? buf_pc_mem[buf_rd_reg] : '0;
   assign pc_plus_four = head_valid ? (buf_pc_mem[buf_rd_reg] + XLEN'(4)) : '0;

   // Control state: fetch pointer, counters, FIFO pointers, fault flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg <= RESET_PC;
         run_reg      <= 1'b0;
         fault_reg    <= 1'b0;
         live_reg     <= '0;
         // Responses to requests issued before reset must still be ignored.
         discard_reg  <= in_flight_left;
         occ_reg      <= '0;
         tag_wr_reg   <= '0;
         tag_rd_reg   <= '0;
         buf_wr_reg   <= '0;
         buf_rd_reg   <= '0;
      end else begin
         run_reg <= 1'b1;
         if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc;
            if (redirect_bad) begin
               fault_reg <= 1'b1;
            end
            live_reg    <= '0;
            discard_reg <= in_flight_left;
            occ_reg     <= '0;
            tag_wr_reg  <= '0;
            tag_rd_reg  <= '0;
            buf_wr_reg  <= '0;
            buf_rd_reg  <= '0;
         end else begin
            if (fire) begin
               fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
               tag_wr_reg   <= tag_wr_reg + PTR_ONE;
            end
            if (resp_live) begin
               tag_rd_reg <= tag_rd_reg + PTR_ONE;
            end
            live_reg    <= live_reg + CW'(fire) - CW'(resp_live);
            discard_reg <= discard_reg - CW'(resp_stale);
            if (push) begin
               buf_wr_reg <= buf_wr_reg + PTR_ONE;
            end
            if (pop) begin
               buf_rd_reg <= buf_rd_reg + PTR_ONE;
            end
            occ_reg <= occ_reg + CW'(push) - CW'(pop);
         end
      end
   end

   // Storage: request addresses on fire, {word, address} pairs on kept responses.
   always_ff @(posedge clk) begin
      if (fire) begin
         tag_mem[tag_wr_reg] <= fetch_pc_reg;
      end
      if (push) begin
         buf_data_mem[buf_wr_reg] <= imem_resp_data;
         buf_pc_mem[buf_wr_reg]   <= tag_mem[tag_rd_reg];
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: an in-order memory model with programmable
// latency, a program-order model of the expected instruction stream, and
// directed phases with hand-computed pins.
module tb_instruction_fetch;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] pc_plus_four;
   logic        misaligned_fault;

   instruction_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .instruction(instruction), .pc(pc), .pc_plus_four(pc_plus_four),
      .misaligned_fault(misaligned_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory model and program-order model
   logic [31:0] addr_q[$];
   int          due_q[$];
   logic [31:0] fire_q[$];
   logic [31:0] cons_pc_q[$];
   logic [31:0] cons_instr_q[$];
   logic [31:0] cons_ppf_q[$];
   int          cons_since_q[$];
   int          cyc = 0;
   int          since = 0;
   int          lat = 1;
   logic        req_ready_k = 1'b1;
   logic        inst_ready_k = 1'b1;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;
   logic        fault_exp = 1'b0;
   logic        prev_req_stall = 1'b0;
   logic        prev_inst_stall = 1'b0;
   logic [31:0] prev_req_addr = '0;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_instr = '0;

   task automatic step(input logic rst, input logic rdv, input logic [31:0] rdpc);
      logic [31:0] tmp_a;
      int          tmp_d;
      logic        fire;
      logic        consume;
      @(negedge clk);
      reset          = rst;
      redirect_valid = rdv;
      redirect_pc    = rdpc;
      imem_req_ready = req_ready_k;
      inst_ready     = inst_ready_k;
      if (addr_q.size() > 0 && due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = word_of(addr_q[0]);
         tmp_a = addr_q.pop_front();
         tmp_d = due_q.pop_front();
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
      if (rst) since = 0;
      else since++;
      #1;
      if (rst || since == 1) begin
         check("quiet_req_valid", 32'(imem_req_valid), 32'd0);
         check("quiet_inst_valid", 32'(inst_valid), 32'd0);
         check("quiet_instruction", instruction, 32'd0);
         check("quiet_pc", pc, 32'd0);
         check("quiet_pc_plus_four", pc_plus_four, 32'd0);
      end else begin
         if (since == 2 && !rdv && (addr_q.size() + int'(imem_resp_valid)) < DEPTH) begin
            check("first_req_valid", 32'(imem_req_valid), 32'd1);
            check("first_req_addr", imem_req_addr, RESET_PC);
         end
         check("fault_flag", 32'(misaligned_fault), 32'(fault_exp));
         if (fault_exp) begin
            check("fault_no_req", 32'(imem_req_valid), 32'd0);
            check("fault_no_inst", 32'(inst_valid), 32'd0);
         end
         if (prev_req_stall && imem_req_valid)
            check("req_addr_hold", imem_req_addr, prev_req_addr);
         if (prev_inst_stall) begin
            check("inst_hold_valid", 32'(inst_valid), 32'd1);
            check("inst_hold_pc", pc, prev_pc);
            check("inst_hold_instr", instruction, prev_instr);
         end
         if (inst_valid) begin
            check("head_pc", pc, exp_pc);
            check("head_instr", instruction, word_of(pc));
            check("head_pc_plus_four", pc_plus_four, pc + 32'd4);
         end
         if (imem_req_valid && imem_req_ready) begin
            check("fetch_addr", imem_req_addr, exp_fetch);
            check("inflight_bound", 32'(addr_q.size() < DEPTH), 32'd1);
         end
      end
      fire = !rst && imem_req_valid && imem_req_ready;
      consume = !rst && !rdv && inst_valid && inst_ready;
      if (fire) begin
         addr_q.push_back(imem_req_addr);
         due_q.push_back(cyc + lat);
         fire_q.push_back(imem_req_addr);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (consume) begin
         cons_pc_q.push_back(pc);
         cons_instr_q.push_back(instruction);
         cons_ppf_q.push_back(pc_plus_four);
         cons_since_q.push_back(since);
         exp_pc = exp_pc + 32'd4;
      end
      prev_req_stall  = !rst && !rdv && imem_req_valid && !imem_req_ready;
      prev_req_addr   = imem_req_addr;
      prev_inst_stall = !rst && !rdv && inst_valid && !inst_ready;
      prev_pc         = pc;
      prev_instr      = instruction;
      if (rst) begin
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
         fault_exp = 1'b0;
      end else if (rdv) begin
         exp_pc    = rdpc;
         exp_fetch = rdpc;
         if (rdpc[1:0] != 2'b00) fault_exp = 1'b1;
      end
      cyc++;
   endtask

   task automatic wait_consumed(input string name, input int target);
      for (int i = 0; i < 40 && cons_pc_q.size() < target; i++) step(1'b0, 1'b0, 32'h0);
      check(name, 32'(cons_pc_q.size() >= target), 32'd1);
   endtask

   initial begin
      int          n0;
      int          f0;
      logic [31:0] hold_pc;
      logic [31:0] hold_addr;
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      imem_resp_valid = 1'b0; imem_resp_data = '0;

      // startup and streaming with 1-cycle memory
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
      check("stream_count", 32'(cons_pc_q.size() >= 4), 32'd1);
      if (cons_pc_q.size() >= 4) begin
         check("stream_pc0", cons_pc_q[0], 32'h0000_0000);
         check("stream_pc1", cons_pc_q[1], 32'h0000_0004);
         check("stream_pc2", cons_pc_q[2], 32'h0000_0008);
         check("stream_pc3", cons_pc_q[3], 32'h0000_000C);
         check("stream_instr2", cons_instr_q[2], 32'hDEAD_BEE7);
         check("stream_first_cycle", 32'(cons_since_q[0]), 32'd4);
         check("stream_fourth_cycle", 32'(cons_since_q[3]), 32'd7);
      end

      // core back-pressure for 5 cycles
      inst_ready_k = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_inst_valid", 32'(inst_valid), 32'd1);
      hold_pc = pc;
      n0 = cons_pc_q.size();
      inst_ready_k = 1'b1;
      wait_consumed("stall_release_timeout", n0 + 3);
      if (cons_pc_q.size() >= n0 + 3) begin
         check("stall_release_pc0", cons_pc_q[n0], hold_pc);
         check("stall_release_pc1", cons_pc_q[n0 + 1], hold_pc + 32'd4);
         check("stall_release_pc2", cons_pc_q[n0 + 2], hold_pc + 32'd8);
      end

      // memory back-pressure for 4 cycles
      req_ready_k = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      hold_addr = imem_req_addr;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      check("mem_stall_addr", imem_req_addr, hold_addr);
      req_ready_k = 1'b1;
      f0 = fire_q.size();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
      check("mem_stall_fired", 32'(fire_q.size() > f0), 32'd1);
      if (fire_q.size() > f0) check("mem_stall_next_fire", fire_q[f0], hold_addr);

      // 3-cycle memory, redirect with two requests in flight
      lat = 3;
      for (int i = 0; i < 20 && addr_q.size() != 2; i++) step(1'b0, 1'b0, 32'h0);
      check("redir_two_outstanding", 32'(addr_q.size()), 32'd2);
      step(1'b0, 1'b1, 32'h0000_0100);
      n0 = cons_pc_q.size();
      wait_consumed("redir_timeout", n0 + 1);
      if (cons_pc_q.size() > n0) check("redir_first_pc", cons_pc_q[n0], 32'h0000_0100);

      // reset while requests are in flight
      for (int i = 0; i < 10 && addr_q.size() == 0; i++) step(1'b0, 1'b0, 32'h0);
      check("rst_mid_outstanding", 32'(addr_q.size() > 0), 32'd1);
      step(1'b1, 1'b0, 32'h0);
      n0 = cons_pc_q.size();
      wait_consumed("rst_mid_timeout", n0 + 2);
      if (cons_pc_q.size() >= n0 + 2) begin
         check("rst_mid_pc0", cons_pc_q[n0], 32'h0000_0000);
         check("rst_mid_pc1", cons_pc_q[n0 + 1], 32'h0000_0004);
      end

      // address wrap at the top of the space
      lat = 1;
      step(1'b0, 1'b1, 32'hFFFF_FFF8);
      n0 = cons_pc_q.size();
      f0 = fire_q.size();
      wait_consumed("wrap_timeout", n0 + 3);
      if (cons_pc_q.size() >= n0 + 3) begin
         check("wrap_pc0", cons_pc_q[n0], 32'hFFFF_FFF8);
         check("wrap_pc1", cons_pc_q[n0 + 1], 32'hFFFF_FFFC);
         check("wrap_ppf1", cons_ppf_q[n0 + 1], 32'h0000_0000);
         check("wrap_pc2", cons_pc_q[n0 + 2], 32'h0000_0000);
      end
      if (fire_q.size() >= f0 + 3) check("wrap_fetch2", fire_q[f0 + 2], 32'h0000_0000);

      // irregular core readiness with 2-cycle memory
      lat = 2;
      for (int i = 0; i < 30; i++) begin
         inst_ready_k = (i % 3 != 0);
         step(1'b0, 1'b0, 32'h0);
      end
      inst_ready_k = 1'b1;

      // misaligned redirect, then reset clears the fault
      step(1'b0, 1'b1, 32'h0000_0102);
      f0 = fire_q.size();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
      check("misalign_fault", 32'(misaligned_fault), 32'd1);
      check("misalign_no_fetch", 32'(fire_q.size()), 32'(f0));
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("misalign_cleared", 32'(misaligned_fault), 32'd0);
      n0 = cons_pc_q.size();
      wait_consumed("misalign_resume_timeout", n0 + 1);
      if (cons_pc_q.size() > n0) check("misalign_resume_pc", cons_pc_q[n0], 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
